// File: rtl/aes_stream_pkg.sv
// ---------------------------------------------------------------------------
// aes_stream_pkg
// Shared definitions for the AES stream controller:
//   - ctrl_state_t   : controller FSM state encoding
//   - WORDS_PER_BLK  : 32-bit stream words per 128-bit AES block
//   - TIMEOUT_DEFAULT: default core-wait timeout in cycles
//   - tmo_cnt_width(): width of the per-state timeout counter
// ---------------------------------------------------------------------------
package aes_stream_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } ctrl_state_t;

    localparam int WORDS_PER_BLK   = 4;
    localparam int TIMEOUT_DEFAULT = 64;

    // The counter only has to reach TIMEOUT-1: it holds the number of
    // cycles already spent in the current wait state.
    function automatic int tmo_cnt_width(input int timeout);
        return (timeout < 3) ? 1 : $clog2(timeout);
    endfunction

    localparam int TMO_W = tmo_cnt_width(TIMEOUT_DEFAULT);

endpackage

// File: rtl/aes_word_serializer.sv
// ---------------------------------------------------------------------------
// aes_word_serializer
// Holds one ciphertext block and emits it as WORDS_PER_BLK stream words,
// most significant word first, with a valid/ready handshake.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_load         capture i_blk (only asserted while the buffer is empty)
//   i_blk          ciphertext block from the core
//   i_m_ready      downstream ready
//   o_m_valid      output word valid (buffer full)
//   o_m_data       current output word, held while i_m_ready is low
//   o_full         buffer occupied (same as o_m_valid, for the controller)
// ---------------------------------------------------------------------------
module aes_word_serializer
    import aes_stream_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int BLK_W  = 128
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [BLK_W-1:0]  i_blk,
    input  logic              i_m_ready,
    output logic              o_m_valid,
    output logic [WORD_W-1:0] o_m_data,
    output logic              o_full
);

    localparam int IDX_W = $clog2(WORDS_PER_BLK);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_BLK - 1);

    logic [BLK_W-1:0]  r_buf;
    logic [IDX_W-1:0]  r_idx;
    logic              r_full;

    logic [WORD_W-1:0] w_words [WORDS_PER_BLK];
    logic              w_fire;
    logic              w_last;

    // Word 0 is the top slice of the block.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_BLK; gi++) begin : g_word
            assign w_words[gi] = r_buf[BLK_W-1-gi*WORD_W -: WORD_W];
        end
    endgenerate

    assign w_fire = r_full & i_m_ready;
    assign w_last = (r_idx == IDX_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_buf  <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_buf  <= i_blk;
            r_idx  <= '0;
            r_full <= 1'b1;
        end else if (w_fire) begin
            if (w_last) begin
                r_full <= 1'b0;
                r_idx  <= '0;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
            end
        end
    end

    assign o_m_valid = r_full;
    assign o_m_data  = w_words[r_idx];
    assign o_full    = r_full;

endmodule

// File: rtl/aes_stream_ctrl.sv
// ---------------------------------------------------------------------------
// aes_stream_ctrl
// Stream front-end/back-end for an AES-128 core. Packs 32-bit words into
// 128-bit blocks, launches the core, waits for its ready handshake, and
// streams the ciphertext back out 32 bits at a time. The input packer can
// fill the next block while the current one is encrypting or draining.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_key_wr, i_key_data   key load (honoured only while idle)
//   i_s_valid/o_s_ready    input word handshake, i_s_data first word = 127:96
//   o_m_valid/i_m_ready    output word handshake, o_m_data first word = 127:96
//   o_busy                 controller not idle
//   o_err, i_err_clr       sticky core timeout flag and its clear
//   o_aes_start            one-cycle launch pulse to the core
//   o_aes_key, o_aes_data  core key and plaintext, stable while busy
//   i_aes_ready, i_aes_dout core ready level and ciphertext
// ---------------------------------------------------------------------------
module aes_stream_ctrl
    import aes_stream_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int BLK_W   = 128,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_key_wr,
    input  logic [BLK_W-1:0]  i_key_data,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [WORD_W-1:0] i_s_data,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [WORD_W-1:0] o_m_data,
    output logic              o_busy,
    output logic              o_err,
    input  logic              i_err_clr,
    output logic              o_aes_start,
    output logic [BLK_W-1:0]  o_aes_key,
    output logic [BLK_W-1:0]  o_aes_data,
    input  logic              i_aes_ready,
    input  logic [BLK_W-1:0]  i_aes_dout
);

    localparam int CNT_W = tmo_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam int IDX_W = $clog2(WORDS_PER_BLK);
    localparam logic [IDX_W-1:0] IN_LAST = IDX_W'(WORDS_PER_BLK - 1);

    // ---------------- state and registers ----------------
    ctrl_state_t        r_state;
    ctrl_state_t        w_state_next;
    logic [CNT_W-1:0]   r_tmo_cnt;
    logic [BLK_W-1:0]   r_key;
    logic [BLK_W-1:0]   r_aes_data;
    logic [BLK_W-1:0]   r_in_buf;
    logic [IDX_W-1:0]   r_in_cnt;
    logic               r_in_full;
    logic               r_s_ready;
    logic               r_err;

    logic               w_s_fire;
    logic               w_in_last;
    logic               w_in_full_next;
    logic               w_out_full;
    logic               w_launch;
    logic               w_capture;
    logic               w_timeout;
    logic               w_aes_start;
    logic               w_tmo_hit;

    // ---------------- input packer ----------------
    assign w_s_fire  = i_s_valid & r_s_ready;
    assign w_in_last = (r_in_cnt == IN_LAST);

    always_comb begin
        w_in_full_next = r_in_full;
        if (w_launch) begin
            w_in_full_next = 1'b0;
        end else if (w_s_fire && w_in_last) begin
            w_in_full_next = 1'b1;
        end
    end

    // s_ready is registered from the next in_full value so that it equals
    // !in_full in normal operation but still reads 0 while reset is held.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_in_buf  <= '0;
            r_in_cnt  <= '0;
            r_in_full <= 1'b0;
            r_s_ready <= 1'b0;
        end else begin
            if (w_s_fire) begin
                r_in_buf <= {r_in_buf[BLK_W-WORD_W-1:0], i_s_data};
                r_in_cnt <= r_in_cnt + IDX_W'(1);
            end
            r_in_full <= w_in_full_next;
            r_s_ready <= !w_in_full_next;
        end
    end

    // ---------------- controller FSM: state register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- controller FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:      if (w_launch)                w_state_next = ISSUE;
            ISSUE:                                  w_state_next = WAIT_LOW;
            WAIT_LOW:  if (!i_aes_ready)            w_state_next = WAIT_HIGH;
                       else if (w_timeout)          w_state_next = IDLE;
            WAIT_HIGH: if (w_capture || w_timeout)  w_state_next = IDLE;
            default:                                w_state_next = IDLE;
        endcase
    end

    // ---------------- controller FSM: outputs / decode ----------------
    // A key write in IDLE takes priority over a launch so the new key is
    // already in place when the deferred launch happens a cycle later.
    always_comb begin
        w_tmo_hit   = (r_tmo_cnt == CNT_LAST);
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_aes_start = 1'b0;
        unique case (r_state)
            IDLE:      w_launch    = r_in_full & !w_out_full & !i_key_wr;
            ISSUE:     w_aes_start = 1'b1;
            WAIT_LOW:  w_timeout   = i_aes_ready & w_tmo_hit;
            WAIT_HIGH: begin
                w_capture = i_aes_ready;
                w_timeout = !i_aes_ready & w_tmo_hit;
            end
            default: ;
        endcase
    end

    // Cycles spent in the current wait state; restarts on every transition.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_tmo_cnt <= '0;
        end else if (r_state == WAIT_LOW || r_state == WAIT_HIGH) begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
    end

    // ---------------- key, core plaintext and error flag ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key      <= '0;
            r_aes_data <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == IDLE && i_key_wr) begin
                r_key <= i_key_data;
            end
            if (w_launch) begin
                r_aes_data <= r_in_buf;
            end
            // A timeout wins over a simultaneous clear.
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // ---------------- output serializer ----------------
    aes_word_serializer #(
        .WORD_W (WORD_W),
        .BLK_W  (BLK_W)
    ) u_ser (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_capture),
        .i_blk     (i_aes_dout),
        .i_m_ready (i_m_ready),
        .o_m_valid (o_m_valid),
        .o_m_data  (o_m_data),
        .o_full    (w_out_full)
    );

    assign o_s_ready   = r_s_ready;
    assign o_busy      = (r_state != IDLE);
    assign o_err       = r_err;
    assign o_aes_start = w_aes_start;
    assign o_aes_key   = r_key;
    assign o_aes_data  = r_aes_data;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_stream_ctrl
// Self-checking bench for aes_stream_ctrl with a behavioural AES core stand-in.
// The stand-in returns the published AES-128 ciphertexts for the two known
// vectors and a simple reversible mix of key and plaintext otherwise.
// ---------------------------------------------------------------------------
module tb_aes_stream_ctrl;

    localparam int TMO = 64;

    localparam logic [127:0] FIPS_KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] FIPS_PT  = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841D02DC09FBDC118597196A0B32;
    localparam logic [127:0] ZERO_PT  = 128'h00000000000000000000000000000001;
    localparam logic [127:0] ZERO_CT  = 128'h58E2FCCEFA7E3061367F1D57A4E7455A;

    logic         clk = 0;
    logic         rst;
    logic         key_wr;
    logic [127:0] key_data;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_data;
    logic         busy;
    logic         err;
    logic         err_clr;
    logic         aes_start;
    logic [127:0] aes_key;
    logic [127:0] aes_data;
    logic         core_ready;
    logic [127:0] core_dout;

    aes_stream_ctrl #(.WORD_W(32), .BLK_W(128), .TIMEOUT(TMO)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_key_wr    (key_wr),
        .i_key_data  (key_data),
        .i_s_valid   (s_valid),
        .o_s_ready   (s_ready),
        .i_s_data    (s_data),
        .o_m_valid   (m_valid),
        .i_m_ready   (m_ready),
        .o_m_data    (m_data),
        .o_busy      (busy),
        .o_err       (err),
        .i_err_clr   (err_clr),
        .o_aes_start (aes_start),
        .o_aes_key   (aes_key),
        .o_aes_data  (aes_data),
        .i_aes_ready (core_ready),
        .i_aes_dout  (core_dout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Core behaviour: known-answer vectors, otherwise a deterministic mix.
    function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] k);
        if (k == FIPS_KEY && pt == FIPS_PT) return FIPS_CT;
        if (k == 128'h0 && pt == ZERO_PT) return ZERO_CT;
        return {pt[95:0], pt[127:96]} ^ k ^ 128'h0123456789ABCDEF_FEDCBA9876543210;
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
        return b[127-32*i -: 32];
    endfunction

    // ---------------- core stand-in ----------------
    int           core_lat  = 3;
    bit           core_hang = 0;
    bit           core_rand = 0;
    int           core_cnt;
    bit           core_busy;
    logic [127:0] core_pt, core_key;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_ready <= 1'b1;
            core_dout  <= '0;
            core_busy  <= 1'b0;
            core_cnt   <= 0;
        end else if (aes_start) begin
            core_ready <= 1'b0;
            core_busy  <= 1'b1;
            core_cnt   <= core_rand ? int'($urandom_range(1, 8)) : core_lat;
            core_pt    <= aes_data;
            core_key   <= aes_key;
        end else if (core_busy) begin
            if (core_cnt > 1) begin
                core_cnt <= core_cnt - 1;
            end else if (!core_hang) begin
                core_ready <= 1'b1;
                core_busy  <= 1'b0;
                core_dout  <= core_fn(core_pt, core_key);
            end
        end
    end

    // ---------------- monitor (samples on the falling edge) ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           start_cnt = 0, start_cyc = 0, last_in_cyc = 0;
    int           rise_cyc = 0, mv_rise_cyc = 0;
    logic [31:0]  out_q[$];
    int           out_cyc_q[$];
    logic [127:0] start_key_q[$];
    logic [127:0] start_data_q[$];
    logic         prev_mv = 0, prev_mr = 0, prev_cr = 1;
    logic [31:0]  prev_md = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_mv = 0; prev_mr = 0; prev_cr = 1;
        end else begin
            if (aes_start) begin
                start_cnt++;
                start_cyc = cyc;
                start_key_q.push_back(aes_key);
                start_data_q.push_back(aes_data);
            end
            if (s_valid && s_ready) last_in_cyc = cyc;
            if (m_valid && m_ready) begin
                out_q.push_back(m_data);
                out_cyc_q.push_back(cyc);
            end
            if (core_ready && !prev_cr) rise_cyc = cyc;
            if (m_valid && !prev_mv) mv_rise_cyc = cyc;
            if (prev_mv && !prev_mr) chk("m_data_hold", {96'h0, m_data}, {96'h0, prev_md});
            prev_mv = m_valid; prev_mr = m_ready; prev_md = m_data; prev_cr = core_ready;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [31:0] w);
        int t = 0;
        s_valid = 1'b1;
        s_data  = w;
        @(negedge clk);
        while (!s_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) chk("send_word_stall", {127'h0, s_ready}, 128'h1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_blk(input logic [127:0] b);
        for (int i = 0; i < 4; i++) send_word(word_of(b, i));
    endtask

    task automatic write_key(input logic [127:0] k);
        key_wr = 1'b1;
        key_data = k;
        @(posedge clk); #1;
        key_wr = 1'b0;
    endtask

    task automatic wait_out(input int n, input string name);
        int t = 0;
        while (out_q.size() < n && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk(name, out_q.size(), n);
    endtask

    task automatic wait_start(input int n, input string name);
        int t = 0;
        while (start_cnt < n && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk(name, start_cnt, n);
    endtask

    task automatic chk_blk_out(input string name, input logic [127:0] ct);
        for (int i = 0; i < 4; i++) begin
            if (out_q.size() > 0) chk(name, {96'h0, out_q.pop_front()}, {96'h0, word_of(ct, i)});
            else chk(name, 0, 1);
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
        out_q.delete(); out_cyc_q.delete(); start_key_q.delete(); start_data_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           lat;
    } vec_t;
    vec_t vecs[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] ka, kb, ba, bb, blk;
        logic [127:0] exp_blk[$];
        logic [31:0]  exp_words[$];
        int base, x;

        vecs[0] = '{FIPS_KEY, FIPS_PT, FIPS_CT, 2};
        vecs[1] = '{128'h0, ZERO_PT, ZERO_CT, 3};
        vecs[2] = '{128'hDEADBEEF_00112233_44556677_8899AABB, 128'hCAFEF00D_01020304_A0B0C0D0_FFFFFFFF, 128'h0, 1};
        vecs[3] = '{128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h0, 128'h0, 6};
        vecs[2].ct = core_fn(vecs[2].pt, vecs[2].key);
        vecs[3].ct = core_fn(vecs[3].pt, vecs[3].key);

        rst = 1; key_wr = 0; key_data = 0; s_valid = 0; s_data = 0;
        m_ready = 0; err_clr = 0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_aes_start", aes_start, 0);
        chk("rst_aes_key", aes_key, 0);
        chk("rst_aes_data", aes_data, 0);
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_s_ready", s_ready, 1);

        // ---- table-driven single blocks, m_ready held high ----
        m_ready = 1;
        for (int v = 0; v < 4; v++) begin
            settle();
            core_lat = vecs[v].lat;
            write_key(vecs[v].key);
            base = start_cnt;
            send_blk(vecs[v].pt);
            wait_out(4, "vec_words");
            chk("vec_start_latency", start_cyc - last_in_cyc, 2);
            chk("vec_mvalid_latency", mv_rise_cyc - rise_cyc, 1);
            chk("vec_key", start_key_q[0], vecs[v].key);
            chk("vec_data", start_data_q[0], vecs[v].pt);
            chk_blk_out("vec_ct", vecs[v].ct);
            repeat (5) @(posedge clk);
            #1;
            chk("vec_one_start", start_cnt - base, 1);
            chk("vec_drained", m_valid, 0);
            $display("vec %0d key=%h pt=%h ct=%h", v, vecs[v].key, vecs[v].pt, vecs[v].ct);
        end

        // ---- back-to-back blocks, output stalled ----
        m_ready = 0;
        settle();
        core_lat = 5;
        ka = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        ba = 128'h11111111_22222222_33333333_44444444;
        bb = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
        write_key(ka);
        base = start_cnt;
        send_blk(ba);
        send_blk(bb);
        repeat (30) @(posedge clk);
        #1;
        chk("b2b_one_start", start_cnt - base, 1);
        chk("b2b_s_ready_low", s_ready, 0);
        chk("b2b_m_valid", m_valid, 1);
        chk("b2b_idle_blocked", busy, 0);
        m_ready = 1;
        wait_start(base + 2, "b2b_second_start");
        if (out_cyc_q.size() >= 4) chk("b2b_start_after_drain", start_cyc - out_cyc_q[3], 2);
        else chk("b2b_drain_count", out_cyc_q.size(), 4);
        wait_out(8, "b2b_words");
        chk_blk_out("b2b_ct_a", core_fn(ba, ka));
        chk_blk_out("b2b_ct_b", core_fn(bb, ka));
        $display("b2b blocks %h %h done", ba, bb);

        // ---- m_ready toggling every cycle ----
        m_ready = 0;
        settle();
        blk = 128'h76543210_FEDCBA98_0BADF00D_13579BDF;
        fork
            send_blk(blk);
            begin
                int t = 0;
                while (out_q.size() < 4 && t < 500) begin
                    m_ready = ~m_ready;
                    @(posedge clk); #1;
                    t++;
                end
            end
        join
        chk("tog_m_valid_clear", m_valid, 0);
        m_ready = 0;
        chk_blk_out("tog_ct", core_fn(blk, ka));
        $display("toggle block %h done", blk);

        // ---- core never completes: timeout ----
        settle();
        core_hang = 1;
        base = start_cnt;
        send_blk(blk);
        wait_start(base + 1, "tmo_start");
        x = start_cyc + 1 + TMO;
        do @(negedge clk); while (cyc < x);
        chk("tmo_err_before", err, 0);
        chk("tmo_busy_before", busy, 1);
        err_clr = 1;                       // coincides with the timeout
        @(negedge clk);
        chk("tmo_err_set", err, 1);
        chk("tmo_busy_clear", busy, 0);
        chk("tmo_no_m_valid", m_valid, 0);
        err_clr = 0;
        @(negedge clk);
        chk("tmo_err_sticky", err, 1);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        chk("tmo_err_clr", err, 0);
        chk("tmo_no_output", out_q.size(), 0);
        core_hang = 0;
        $display("timeout after %0d cycles flagged", TMO);

        // ---- key write while busy, and coincident with a pending launch ----
        settle();
        m_ready = 1;
        core_lat = 12;
        kb = 128'h55555555_66666666_77777777_88888888;
        base = start_cnt;
        send_blk(blk);
        wait_start(base + 1, "kwr_start");
        repeat (4) @(posedge clk);
        #1;
        write_key(kb);
        chk("kwr_busy_ignored", aes_key, ka);
        wait_out(4, "kwr_words");
        chk_blk_out("kwr_ct_old_key", core_fn(blk, ka));
        settle();
        base = start_cnt;
        send_blk(ba);
        write_key(kb);
        wait_start(base + 1, "kco_start");
        chk("kco_deferred", start_cyc - last_in_cyc, 3);
        chk("kco_new_key", start_key_q[0], kb);
        wait_out(4, "kco_words");
        chk_blk_out("kco_ct", core_fn(ba, kb));
        $display("key collision block %h key %h done", ba, kb);

        // ---- reset mid-WAIT_HIGH, partial words dropped ----
        settle();
        core_lat = 30;
        base = start_cnt;
        send_blk(bb);
        wait_start(base + 1, "mrst_start");
        send_word(32'h99999999);
        send_word(32'h88888888);
        repeat (3) @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_aes_start", aes_start, 0);
        chk("mrst_aes_key", aes_key, 0);
        chk("mrst_aes_data", aes_data, 0);
        chk("mrst_m_valid", m_valid, 0);
        chk("mrst_m_data", m_data, 0);
        chk("mrst_s_ready", s_ready, 0);
        chk("mrst_err", err, 0);
        @(posedge clk); #1;
        rst = 0;
        settle();
        core_lat = 2;
        write_key(kb);
        send_blk(ba);
        wait_out(4, "mrst_after_words");
        chk_blk_out("mrst_after_ct", core_fn(ba, kb));
        $display("reset mid-operation recovered");

        // ---- randomized streams against the model ----
        core_rand = 1;
        for (int g = 0; g < 3; g++) begin
            settle();
            ka = {$urandom, $urandom, $urandom, $urandom};
            write_key(ka);
            exp_blk.delete();
            exp_words.delete();
            for (int b = 0; b < 5; b++) begin
                blk = {$urandom, $urandom, $urandom, $urandom};
                exp_blk.push_back(blk);
                for (int i = 0; i < 4; i++) exp_words.push_back(word_of(core_fn(blk, ka), i));
            end
            fork
                begin
                    for (int b = 0; b < 5; b++) begin
                        for (int i = 0; i < 4; i++) begin
                            repeat ($urandom_range(0, 2)) begin
                                @(posedge clk); #1;
                            end
                            send_word(word_of(exp_blk[b], i));
                        end
                    end
                end
                begin
                    int t = 0;
                    while (out_q.size() < 20 && t < 5000) begin
                        m_ready = $urandom_range(0, 1);
                        @(posedge clk); #1;
                        t++;
                    end
                    m_ready = 0;
                end
            join
            chk("rnd_word_count", out_q.size(), 20);
            for (int b = 0; b < 5; b++) begin
                if (b < start_data_q.size()) chk("rnd_block_in", start_data_q[b], exp_blk[b]);
                else chk("rnd_block_count", start_data_q.size(), 5);
            end
            for (int i = 0; i < 20 && out_q.size() > 0; i++)
                chk("rnd_word", {96'h0, out_q.pop_front()}, {96'h0, exp_words[i]});
            $display("random group %0d key=%h 5 blocks", g, ka);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
